addsub_nibble_sequencer: RTL
============================

ADDSUB_NIBBLE_SEQUENCER -- requirements
Module: addsub_nibble_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; multiple of 4, at least 8.
REQ-002 SHALL use derived constant NIB = WIDTH/4, the number of nibble steps.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-008 SHALL have ports a, b  input  WIDTH  operands, two's complement.
REQ-009 SHALL have port flush  input  1  synchronous abort.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  sum/difference.
REQ-013 SHALL have ports cout, overflow, zero  output  1 each  carry-out (no-borrow on subtract), signed overflow, result==0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE: on in_valid&in_ready, latch a, (op ? ~b : b), carry=op, nibble counter=0, clear result register; go CALC.
REQ-016 CALC: each cycle, pass nibble[cnt] of latched operands plus carry register through one 4-bit carry look-ahead slice; write the sum into result[4*cnt+3:4*cnt], update carry register from slice carry-out, increment cnt.
REQ-017 On cnt==NIB-1: capture cout = slice carry-out; overflow = carry into MSB XOR carry out of MSB; zero = (final result==0); go DONE.
REQ-018 Latency: out_valid SHALL rise exactly NIB rising edges after the accepting edge (4 for WIDTH=16).
REQ-019 DONE: result/cout/overflow/zero held stable while out_valid&!out_ready (backpressure unbounded).
REQ-020 DONE with out_ready=1: go IDLE; in_ready=1 the following cycle (no same-cycle accept; max throughput one op per NIB+2 cycles).
REQ-021 flush=1 in any state: next state IDLE, pending operation discarded, out_valid low next cycle; flush overrides in_valid and out_ready in the same cycle.
REQ-022 Operand inputs SHALL be ignored outside the IDLE accept cycle; changes during CALC do not affect the result.
REQ-023 Wrap-around: result is modulo 2^WIDTH; carry beyond MSB appears only on cout.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, cnt=0, carry=0, result=0, cout=0, overflow=0, zero=0, out_valid=0; in_ready=1 once rst_n is high.
REQ-025 Reset mid-CALC or DONE SHALL drop the operation with no output handshake.

Structure
REQ-026 Shared package SHALL hold the state enum (IDLE, CALC, DONE) and the OP_ADD/OP_SUB encodings.
REQ-027 One sub-module SHALL be instantiated: cla4_slice (4-bit a, b, cin -> sum, cout, carry-look-ahead generate/propagate); the FSM, counter, and registers stay in the top module.

Verification
REQ-028 add 0x1234+0x0FFF -> out_valid 4 cycles after accept, result 0x2233, cout 0, overflow 0, zero 0.
REQ-029 add 0x7FFF+0x0001 -> 0x8000, overflow 1, cout 0; add 0xFFFF+0x0001 -> 0x0000, cout 1, zero 1, overflow 0.
REQ-030 sub 0x0005-0x0007 -> 0xFFFE, cout 0 (borrow); sub 0x8000-0x0001 -> 0x7FFF, cout 1, overflow 1.
REQ-031 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready 0; out_ready=1 -> IDLE next cycle, in_ready 1.
REQ-032 flush at cnt=2, then reset asserted mid-CALC of a second op -> IDLE each time, no out_valid pulse, next op 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/addsub_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   state_e : sequencer FSM states (IDLE, CALC, DONE)
//   OP_ADD / OP_SUB : encodings of the op input
package addsub_nibble_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_nibble_sequencer_if.sv
// Request/response bundle of the nibble-serial add/subtract sequencer.
//   Request : in_valid, in_ready, op, a, b, flush
//   Response: out_valid, out_ready, result, cout, overflow, zero
//   slave modport  : the sequencer side
//   master modport : the requester/consumer side
interface addsub_nibble_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero
    );

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero
    );
endinterface

// File: rtl/addsub_nibble_sequencer_cla4_slice.sv
// 4-bit carry look-ahead adder slice.
//   a_i, b_i : 4-bit operand nibbles
//   cin_i    : carry into bit 0
//   sum_o    : 4-bit sum
//   cout_o   : carry out of bit 3, formed from group generate/propagate
module cla4_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;
    logic       grp_g_s;
    logic       grp_p_s;

    assign g_s = a_i & b_i;
    assign p_s = a_i ^ b_i;

    // Every internal carry is expanded directly from generate/propagate so
    // no carry ripples through another.
    assign c_s[0] = cin_i;
    assign c_s[1] = g_s[0] | (p_s[0] & cin_i);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin_i);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin_i);

    assign grp_g_s = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                   | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign grp_p_s = &p_s;
    assign c_s[4]  = grp_g_s | (grp_p_s & cin_i);

    assign sum_o  = p_s ^ c_s[3:0];
    assign cout_o = c_s[4];
endmodule

// File: rtl/addsub_nibble_sequencer.sv
// Nibble-serial two's-complement adder/subtractor.
// A request accepted in IDLE is processed one nibble per cycle through a
// single 4-bit CLA slice; the result is presented in DONE until consumed.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of addsub_nibble_sequencer_if (request, response,
//           flush abort)
module addsub_nibble_sequencer
    import addsub_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    addsub_nibble_sequencer_if.slave    bus
);
    localparam int              NIB      = WIDTH / 4;
    localparam int              CW       = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(NIB - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [CW+1:0]      bit_idx_s;
    logic [3:0]         a_nib_s;
    logic [3:0]         b_nib_s;
    logic [3:0]         sum_nib_s;
    logic               slice_cout_s;
    logic               msb_cin_s;

    assign bit_idx_s = {cnt_q, 2'b00};
    assign a_nib_s   = a_q[bit_idx_s +: 4];
    assign b_nib_s   = b_q[bit_idx_s +: 4];

    cla4_slice u_slice (
        .a_i    (a_nib_s),
        .b_i    (b_nib_s),
        .cin_i  (carry_q),
        .sum_o  (sum_nib_s),
        .cout_o (slice_cout_s)
    );

    // Carry into the top bit of the nibble, recovered from its sum bit.
    assign msb_cin_s = a_nib_s[3] ^ b_nib_s[3] ^ sum_nib_s[3];

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (bus.flush) begin
            // Abort wins over any handshake in the same cycle.
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is a + ~b + 1: invert b, seed carry.
                        a_d      = bus.a;
                        b_d      = (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        carry_d  = (bus.op == OP_SUB);
                        cnt_d    = {CW{1'b0}};
                        result_d = {WIDTH{1'b0}};
                        cout_d   = 1'b0;
                        ovf_d    = 1'b0;
                        zero_d   = 1'b0;
                        state_d  = CALC;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                CALC: begin
                    result_d[bit_idx_s +: 4] = sum_nib_s;
                    carry_d                  = slice_cout_s;
                    if (cnt_q == LAST_CNT) begin
                        cout_d  = slice_cout_s;
                        ovf_d   = msb_cin_s ^ slice_cout_s;
                        zero_d  = (result_d == {WIDTH{1'b0}});
                        cnt_d   = {CW{1'b0}};
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule
